fifo_burst_writer: RTL
======================

Name: fifo_burst_writer

Overview:
- Write-domain producer for the async FIFO. Drives winc/wdata into the FIFO write port and honours wfull.
- On a start request it writes a burst of burst_len words. Data is an incrementing count from seed, or an LFSR sequence when FIFO_WR_LFSR_EN is defined.
- Used by stress benches and on-chip loopback to fill the FIFO from the wclk domain. The matching reader runs on rclk.

Parameters:
- DATASIZE, definitions::DATASIZE (8), width of wdata and seed; must match the FIFO.
- LENW, 8, width of burst_len and the remaining-words counter.
- CNTW, 16, width of the running total words_written counter.

Ports:
- wclk  input  1  write-domain clock
- wrst_n  input  1  reset, asynchronous, active-low
- start  input  1  burst request; sampled only in IDLE
- burst_len  input  LENW  words to write; sampled with start
- seed  input  DATASIZE  first data word; sampled with start
- abort  input  1  terminate current burst
- wfull  input  1  FIFO full flag (registered, wclk domain)
- winc  output  1  write request to FIFO
- wdata  output  DATASIZE  write data to FIFO
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at burst end
- aborted  output  1  qualifies done: burst was cut short
- words_written  output  CNTW  total accepted writes since reset

Behaviour:
- Reset values: state=IDLE; winc=0, busy=0, done=0, aborted=0, wdata=0, words_written=0, remaining=0.
- Accept rule: a word is accepted on a wclk edge when winc=1 and wfull=0. This is the same qualification the FIFO uses internally. winc held high while wfull=1 writes nothing.
- States: IDLE, WRITE.
- IDLE, start=1, burst_len!=0:
  - latch remaining=burst_len and data register=seed.
  - next cycle: state=WRITE, busy=1.
- IDLE, start=1, burst_len=0: no writes; done=1 (aborted=0) on the next cycle; stay in IDLE.
- WRITE:
  - winc=1 every cycle, decoded from state, no extra register.
  - wdata = data register.
  - On accept: data register advances (+1 mod 2^DATASIZE, or LFSR step), remaining decrements, words_written increments (wraps mod 2^CNTW).
- WRITE, accept with remaining==1: next edge state=IDLE, busy=0, done=1 for one cycle, aborted=0. First write of a new burst is no earlier than the cycle after done.
- WRITE, wfull=1: hold wdata, remaining and state; winc stays 1. No timeout.
- Latency: start edge to first winc = 1 cycle. An N-word burst with wfull=0 throughout gives exactly N consecutive winc cycles; done asserts the cycle after the last one.
- start while busy: ignored, no queuing.
- abort in WRITE:
  - takes priority over completion.
  - if the same edge accepts a word, that word counts in words_written.
  - next cycle: state=IDLE, winc=0, done=1, aborted=1.
- abort in IDLE: ignored.
- aborted holds its value until the next done pulse.
- wrst_n assertion mid-burst: immediate return to reset values, winc=0 asynchronously. No done pulse.

Optional Feature:
- Macro: FIFO_WR_LFSR_EN.
- Defined: the data register is a Galois LFSR of width DATASIZE using the maximal-length tap constant from the package.
  - seed==0 is replaced by all-ones, since all-zero is a lockup state.
  - the LFSR advances only on accept.
- Undefined: data advances by +1 mod 2^DATASIZE; seed 0 is legal.

Decomposition:
- Package definitions (shared with FIFO):
  - DATASIZE, ADDRSIZE
  - new: typedef enum logic {IDLE, WRITE} wr_state_t
  - new: LFSR_TAPS constant per DATASIZE (8-bit: 8'hB8)
- One sub-module: fifo_wr_datagen. Holds the data register, the seed load, and the +1/LFSR next-value logic, with inputs load and step.

Test Plan:
- seed=8'h10, burst_len=4, wfull=0 -> winc high for 4 cycles; wdata=10,11,12,13; done one cycle later with aborted=0; words_written=4.
- burst_len=20 into an ADDRSIZE=4 FIFO, no reads -> wfull asserts; 16 words accepted; winc held with wdata=seed+16; busy=1. Read 4 words on rclk -> remaining 4 written; done; words_written=20.
- burst_len=0 with start -> winc never asserts; done=1 the next cycle; aborted=0; words_written unchanged.
- burst_len=10, abort after the 3rd accept -> exactly 3 words written; done=1 with aborted=1; a later start with len=2 writes 2 words and clears aborted.
- start pulsed mid-burst, then wrst_n dropped mid-burst -> the extra start is ignored; on reset winc drops immediately and all outputs take reset values.
- FIFO_WR_LFSR_EN defined, seed=0, len=3 -> first word 8'hFF, then the two following LFSR states; sequence matches the reference model.

Source files
------------

// File: rtl/definitions.sv
// Shared definitions for the async FIFO and its write-domain burst producer.
// Holds the FIFO geometry, the writer FSM state type and the Galois LFSR
// toggle masks used when FIFO_WR_LFSR_EN is defined.
package definitions;

    localparam int DATASIZE = 8;
    localparam int ADDRSIZE = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_t;

    // Right-shifting Galois toggle masks giving a maximal-length sequence.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0E08;
            13:      taps = 32'h0000_1C80;
            14:      taps = 32'h0000_3802;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_B400;
            default: taps = 32'h0000_00B8;
        endcase
        return taps;
    endfunction

    localparam logic [DATASIZE-1:0] LFSR_TAPS = DATASIZE'(lfsr_taps(DATASIZE));

endpackage

// File: rtl/fifo_wr_datagen.sv
// Data register for the burst writer: loads the seed and advances by one
// step per accepted word. Default build counts up by one; with
// FIFO_WR_LFSR_EN defined it runs a Galois LFSR instead.
module fifo_wr_datagen
    import definitions::*;
#(
    parameter int W = DATASIZE
) (
    input  logic         wclk,
    input  logic         wrst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] seed,
    output logic [W-1:0] data
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic [W-1:0] seed_val;
    logic [W-1:0] next_val;

`ifdef FIFO_WR_LFSR_EN
    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    // All-zero is the LFSR lockup state, so a zero seed starts from all-ones.
    always_comb begin
        seed_val = (seed == '0) ? {W{1'b1}} : seed;
        next_val = data_q[0] ? ((data_q >> 1) ^ TAPS) : (data_q >> 1);
    end
`else
    // Plain incrementing count; wraps naturally and zero is a legal seed.
    always_comb begin
        seed_val = seed;
        next_val = data_q + W'(1);
    end
`endif

    // Load has priority; otherwise advance only when a word was accepted.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = seed_val;
        end else if (step) begin
            data_d = next_val;
        end
    end

    // Data register.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/fifo_burst_writer.sv
// Write-domain burst producer for the async FIFO. On start it writes
// burst_len words (count from seed, or LFSR when FIFO_WR_LFSR_EN is defined),
// honouring wfull, and pulses done at the end of the burst.
//
// Handshake: a word is transferred on a wclk edge exactly when winc=1 and
// wfull=0. winc is decoded straight from the WRITE state, so it stays high
// while the FIFO is full and nothing is written in those cycles.
module fifo_burst_writer
    import definitions::*;
#(
    parameter int DATASIZE = definitions::DATASIZE,
    parameter int LENW     = 8,
    parameter int CNTW     = 16
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                start,
    input  logic [LENW-1:0]     burst_len,
    input  logic [DATASIZE-1:0] seed,
    input  logic                abort,
    input  logic                wfull,
    output logic                winc,
    output logic [DATASIZE-1:0] wdata,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [CNTW-1:0]     words_written
);

    wr_state_t       state_q;
    wr_state_t       state_d;
    logic [LENW-1:0] remaining_q;
    logic [LENW-1:0] remaining_d;
    logic [CNTW-1:0] words_q;
    logic [CNTW-1:0] words_d;
    logic            done_q;
    logic            done_d;
    logic            aborted_q;
    logic            aborted_d;
    logic            load;
    logic            step;
    logic            accept;

    assign winc   = (state_q == WRITE);
    assign accept = winc && !wfull;

    // Next-state logic: burst launch, per-word bookkeeping, end/abort.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        words_d     = words_q;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        load        = 1'b0;
        step        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_d     = WRITE;
                        remaining_d = burst_len;
                        load        = 1'b1;
                    end else begin
                        // Empty burst completes immediately without writing.
                        done_d    = 1'b1;
                        aborted_d = 1'b0;
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    step        = 1'b1;
                    remaining_d = remaining_q - LENW'(1);
                    words_d     = words_q + CNTW'(1);
                end
                // Abort wins over completion; a word accepted on the same
                // edge has already been counted above.
                if (abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                    done_d      = 1'b1;
                    aborted_d   = 1'b1;
                end else if (accept && (remaining_q == LENW'(1))) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            words_q     <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            words_q     <= words_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    fifo_wr_datagen #(
        .W (DATASIZE)
    ) u_datagen (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .load   (load),
        .step   (step),
        .seed   (seed),
        .data   (wdata)
    );

    assign busy          = (state_q == WRITE);
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign words_written = words_q;

endmodule
